// File: rtl/serial2parallel_framed_if.sv
// Framed serial input and valid/ack parallel output bundle for serial2parallel_framed.
// The slave modport is the converter; the master modport is the pin driver and consumer side.
interface serial2parallel_framed_if #(
  parameter int unsigned DATA_WIDTH = 15
);
  logic                  serial_data;
  logic                  frame_n;
  logic                  data_ack;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  overrun;
  logic                  frame_error;
  logic                  parity_error;

  modport master (
    output serial_data,
    output frame_n,
    output data_ack,
    input  data_out,
    input  data_valid,
    input  overrun,
    input  frame_error,
    input  parity_error
  );

  modport slave (
    input  serial_data,
    input  frame_n,
    input  data_ack,
    output data_out,
    output data_valid,
    output overrun,
    output frame_error,
    output parity_error
  );
endinterface

// File: rtl/serial2parallel_framed.sv
// Framed serial-to-parallel converter with valid/ack hand-off, overrun and frame-abort reporting.
// Define S2P_PARITY_EN to expect a trailing even-parity bit per frame and report parity_error.
module serial2parallel_framed #(
  parameter int unsigned DATA_WIDTH = 15,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input logic                     serial_clock,
  input logic                     reset,
  serial2parallel_framed_if.slave bus
);

`ifdef S2P_PARITY_EN
  localparam int unsigned WordBits = DATA_WIDTH + 1;
`else
  localparam int unsigned WordBits = DATA_WIDTH;
`endif
  localparam int unsigned   CntW    = $clog2(WordBits + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WordBits - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  overrun_q;
  logic                  frame_err_q;

  logic [DATA_WIDTH-1:0] sreg_shifted;
  logic [DATA_WIDTH-1:0] word;
  logic                  shift_en;
  logic                  complete;
  logic                  load;

  always_comb begin
    sreg_shifted = MSB_FIRST ? {sreg_q[DATA_WIDTH-2:0], bus.serial_data}
                             : {bus.serial_data, sreg_q[DATA_WIDTH-1:1]};
    complete     = !bus.frame_n && (cnt_q == LastCnt);
    load         = complete && (!valid_q || bus.data_ack);
`ifdef S2P_PARITY_EN
    // The last bit is parity: it is checked but never shifted into the word.
    shift_en     = (cnt_q != LastCnt);
    word         = sreg_q;
`else
    shift_en     = 1'b1;
    word         = sreg_shifted;
`endif
  end

`ifdef S2P_PARITY_EN
  logic parity_q;

  always_ff @(posedge serial_clock or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= (^sreg_q) ^ bus.serial_data;
    end
  end

  assign bus.parity_error = parity_q;
`else
  assign bus.parity_error = 1'b0;
`endif

  always_ff @(posedge serial_clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sreg_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;

      if (!bus.frame_n) begin
        if (shift_en) begin
          sreg_q <= sreg_shifted;
        end
        if (complete) begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end else begin
          cnt_q   <= cnt_q + CntW'(1);
          state_q <= StShift;
        end
      end else if (state_q == StShift) begin
        // Frame released mid-word: drop the partial word, leave the held word alone.
        cnt_q       <= '0;
        state_q     <= StIdle;
        frame_err_q <= 1'b1;
      end

      if (load) begin
        data_q  <= word;
        valid_q <= 1'b1;
      end else if (complete) begin
        overrun_q <= 1'b1;
      end else if (valid_q && bus.data_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_error = frame_err_q;

endmodule

// File: tb/tb_serial2parallel_framed.sv
// Bench for serial2parallel_framed: a 15-bit MSB-first and an 8-bit LSB-first instance share
// one random serial stream and are compared against a bit-position reference model.
module tb_serial2parallel_framed;

`ifdef S2P_PARITY_EN
  localparam int Par = 1;
`else
  localparam int Par = 0;
`endif

  logic serial_clock = 1'b0;
  logic reset        = 1'b1;
  logic sd           = 1'b0;
  logic fn           = 1'b1;
  logic ack          = 1'b0;

  int checks   = 0;
  int failures = 0;

  serial2parallel_framed_if #(.DATA_WIDTH(15)) bus0 ();
  serial2parallel_framed_if #(.DATA_WIDTH(8))  bus1 ();

  assign bus0.serial_data = sd;
  assign bus0.frame_n     = fn;
  assign bus0.data_ack    = ack;
  assign bus1.serial_data = sd;
  assign bus1.frame_n     = fn;
  assign bus1.data_ack    = ack;

  serial2parallel_framed #(.DATA_WIDTH(15), .MSB_FIRST(1'b1)) dut0 (
    .serial_clock (serial_clock),
    .reset        (reset),
    .bus          (bus0.slave)
  );

  serial2parallel_framed #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .serial_clock (serial_clock),
    .reset        (reset),
    .bus          (bus1.slave)
  );

  always #5 serial_clock = ~serial_clock;

  // Reference state: index 0 = 15-bit MSB-first, index 1 = 8-bit LSB-first.
  int          mcnt  [2];
  logic [31:0] macc  [2];
  logic [31:0] mout  [2];
  logic        mpar  [2];
  logic        mval  [2];
  logic        movr  [2];
  logic        mferr [2];
  logic        mperr [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; macc[k] = '0; mout[k] = '0; mpar[k] = 1'b0;
      mval[k] = 1'b0; movr[k] = 1'b0; mferr[k] = 1'b0; mperr[k] = 1'b0;
    end
  endtask

  // Bit number i of a frame lands at position W-1-i (MSB first) or i (LSB first).
  task automatic model_edge(input int k, input logic b, input logic f, input logic a);
    int w;
    int pos;
    w = (k == 0) ? 15 : 8;
    mferr[k] = 1'b0;
    if (!f) begin
      if (mcnt[k] < w) begin
        pos = (k == 0) ? (w - 1 - mcnt[k]) : mcnt[k];
        macc[k][pos] = b;
      end
      mpar[k] = mpar[k] ^ b;
      mcnt[k]++;
      if (mcnt[k] == w + Par) begin
        if (!mval[k] || a) begin
          mout[k]  = macc[k];
          mval[k]  = 1'b1;
          mperr[k] = (Par != 0) ? mpar[k] : 1'b0;
        end else begin
          movr[k] = 1'b1;
        end
        mcnt[k] = 0; macc[k] = '0; mpar[k] = 1'b0;
      end else if (mval[k] && a) begin
        mval[k] = 1'b0;
      end
    end else begin
      if (mcnt[k] != 0) mferr[k] = 1'b1;
      mcnt[k] = 0; macc[k] = '0; mpar[k] = 1'b0;
      if (mval[k] && a) mval[k] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("d0_out",   32'(bus0.data_out),     mout[0]);
    check("d0_valid", 32'(bus0.data_valid),   32'(mval[0]));
    check("d0_ovr",   32'(bus0.overrun),      32'(movr[0]));
    check("d0_ferr",  32'(bus0.frame_error),  32'(mferr[0]));
    check("d0_perr",  32'(bus0.parity_error), 32'(mperr[0]));
    check("d1_out",   32'(bus1.data_out),     mout[1]);
    check("d1_valid", 32'(bus1.data_valid),   32'(mval[1]));
    check("d1_ovr",   32'(bus1.overrun),      32'(movr[1]));
    check("d1_ferr",  32'(bus1.frame_error),  32'(mferr[1]));
    check("d1_perr",  32'(bus1.parity_error), 32'(mperr[1]));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step(input logic b, input logic f, input logic a);
    sd = b; fn = f; ack = a;
    @(posedge serial_clock);
    model_edge(0, b, f, a);
    model_edge(1, b, f, a);
    @(negedge serial_clock);
    compare_all();
  endtask

  task automatic send_word(input logic [31:0] v, input int n, input logic pbit,
                           input logic ack_last);
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b0, (i == 0 && Par == 0) ? ack_last : 1'b0);
    if (Par != 0) step(pbit, 1'b0, ack_last);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    fn = 1'b1; ack = 1'b0;
    #1;
    check("rst_out0",  32'(bus0.data_out),     32'h0);
    check("rst_val0",  32'(bus0.data_valid),   32'h0);
    check("rst_ovr0",  32'(bus0.overrun),      32'h0);
    check("rst_ferr0", 32'(bus0.frame_error),  32'h0);
    check("rst_perr0", 32'(bus0.parity_error), 32'h0);
    check("rst_out1",  32'(bus1.data_out),     32'h0);
    check("rst_val1",  32'(bus1.data_valid),   32'h0);
    model_reset();
    @(negedge serial_clock);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    logic [31:0] w;
    model_reset();
    repeat (2) @(negedge serial_clock);
    compare_all();
    reset = 1'b0;

    // Single MSB-first word.
    send_word(32'h5A5A, 15, ^15'h5A5A, 1'b0);
    check("t1_data",  32'(bus0.data_out),    32'h5A5A);
    check("t1_valid", 32'(bus0.data_valid),  32'h1);
    check("t1_ovr",   32'(bus0.overrun),     32'h0);
    check("t1_ferr",  32'(bus0.frame_error), 32'h0);

    // LSB-first instance: first bit lands in bit 0; ack clears valid, data holds.
    do_reset();
    send_word(32'h80, 8, 1'b1, 1'b0);
    check("t2_data",  32'(bus1.data_out),   32'h01);
    check("t2_valid", 32'(bus1.data_valid), 32'h1);
    step(1'b0, 1'b1, 1'b1);
    check("t2_ackv",  32'(bus1.data_valid), 32'h0);
    check("t2_ackd",  32'(bus1.data_out),   32'h01);

    // Back-to-back words without ack: second dropped, overrun sticky.
    do_reset();
    send_word(32'h1234, 15, ^15'h1234, 1'b0);
    send_word(32'h0F0F, 15, ^15'h0F0F, 1'b0);
    check("t3_data", 32'(bus0.data_out),   32'h1234);
    check("t3_val",  32'(bus0.data_valid), 32'h1);
    check("t3_ovr",  32'(bus0.overrun),    32'h1);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check("t3_ovr_sticky", 32'(bus0.overrun), 32'h1);

    // Ack on the completing edge accepts the new word.
    do_reset();
    send_word(32'h1234, 15, ^15'h1234, 1'b0);
    send_word(32'h0F0F, 15, ^15'h0F0F, 1'b1);
    check("t4_data", 32'(bus0.data_out),   32'h0F0F);
    check("t4_val",  32'(bus0.data_valid), 32'h1);
    check("t4_ovr",  32'(bus0.overrun),    32'h0);

    // Aborted frame, then a full word.
    do_reset();
    repeat (7) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check("t5_ferr",  32'(bus0.frame_error), 32'h1);
    check("t5_val",   32'(bus0.data_valid),  32'h0);
    step(1'b0, 1'b1, 1'b0);
    check("t5_ferr_pulse", 32'(bus0.frame_error), 32'h0);
    send_word(32'h7FFF, 15, ^15'h7FFF, 1'b0);
    check("t5_data", 32'(bus0.data_out), 32'h7FFF);

    // Reset mid-word, then a clean frame.
    do_reset();
    repeat (9) step(1'b1, 1'b0, 1'b0);
    do_reset();
    send_word(32'h2AB3, 15, ^15'h2AB3, 1'b0);
    check("t6_data", 32'(bus0.data_out), 32'h2AB3);

`ifdef S2P_PARITY_EN
    do_reset();
    send_word(32'h0001, 15, 1'b0, 1'b1);
    check("t6_perr_bad", 32'(bus0.parity_error), 32'h1);
    send_word(32'h0001, 15, 1'b1, 1'b1);
    check("t6_perr_ok",  32'(bus0.parity_error), 32'h0);
`endif

    // Random stream with sporadic frame drops, acks and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(599) == 0) do_reset();
      w = $urandom;
      step(w[0], ($urandom_range(15) == 0), ($urandom_range(3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
